tick_scheduler: RTL and testbench

Programmable multi-channel timebase controller that replaces fixed-ratio slow-clock dividers with run-time configurable ones. Each channel holds a terminal count, a mode and an enable, written through a single shared configuration port. From the system clock it produces a one-cycle `tick` enable pulse and a 50%-duty `div_clk` square wave per channel. It sits between the board clock and the display, debounce and scan logic, which consume `tick` as a clock enable.

---
 rtl/tick_scheduler_if.sv | 23 ++
 rtl/tick_scheduler.sv | 111 +++++++++++
 tb/tb_tick_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler: one shared write channel with
// a registered accept/reject response.
interface tick_scheduler_if #(
  parameter int CNT_W = 26
);
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_mode;
  logic             cfg_en;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_en,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_en,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/tick_scheduler.sv
// Programmable multi-channel timebase: each channel emits a one-cycle tick
// every period+1 cycles and a div_clk square wave toggling on each tick.
module tick_scheduler #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  tick_scheduler_if.slave  cfg,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  div_clk,
  output logic [N_CH-1:0]  active
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [2:0] N_CH_L  = 3'(N_CH);

  logic [1:0]       state  [N_CH];
  logic [CNT_W-1:0] period [N_CH];
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [N_CH-1:0]  mode;

  logic             wr_ok;
  logic             wr_bad;
  logic [N_CH-1:0]  wr_sel;

  // Classify the configuration write and one-hot select the target channel
  always_comb begin
    wr_ok  = 1'b0;
    wr_bad = 1'b0;
    wr_sel = '0;
    if (cfg.cfg_we) begin
      if ({1'b0, cfg.cfg_ch} < N_CH_L) begin
        wr_ok = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          wr_sel[i] = (cfg.cfg_ch == 2'(i));
        end
      end else begin
        wr_bad = 1'b1;
      end
    end else begin
      wr_ok  = 1'b0;
      wr_bad = 1'b0;
    end
  end

  // Per-channel counters, FSMs and registered outputs; a write overrides any tick due that edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      tick        <= '0;
      div_clk     <= '0;
      active      <= '0;
      mode        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= ST_IDLE;
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      cfg.cfg_ack <= wr_ok;
      cfg.cfg_err <= wr_bad;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_sel[i]) begin
          period[i]  <= cfg.cfg_period;
          mode[i]    <= cfg.cfg_mode;
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          div_clk[i] <= 1'b0;
          active[i]  <= cfg.cfg_en;
          state[i]   <= cfg.cfg_en ? ST_RUN : ST_IDLE;
        end else begin
          case (state[i])
            ST_RUN: begin
              if (cnt[i] == period[i]) begin
                cnt[i]     <= '0;
                tick[i]    <= 1'b1;
                div_clk[i] <= ~div_clk[i];
                if (mode[i]) begin
                  state[i]  <= ST_HALT;
                  active[i] <= 1'b0;
                end else begin
                  state[i]  <= ST_RUN;
                  active[i] <= 1'b1;
                end
              end else begin
                cnt[i]  <= cnt[i] + CNT_W'(1);
                tick[i] <= 1'b0;
              end
            end
            ST_IDLE, ST_HALT: begin
              cnt[i]    <= '0;
              tick[i]   <= 1'b0;
              active[i] <= 1'b0;
            end
            default: begin
              state[i]  <= ST_IDLE;
              cnt[i]    <= '0;
              tick[i]   <= 1'b0;
              active[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a cycle-indexed arithmetic model checked
// every cycle, plus literal expectations taken from hand-worked timelines.
module tb_tick_scheduler;
  localparam int N_CH  = 3;
  localparam int CNT_W = 26;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] div_clk;
  logic [N_CH-1:0] active;

  tick_scheduler_if #(.CNT_W(CNT_W)) cfg ();

  tick_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg),
    .tick    (tick),
    .div_clk (div_clk),
    .active  (active)
  );

  always #5 clk = ~clk;

  int     cyc     = 0;
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     chk_en  = 1'b0;

  // Model: per channel, the cycle a write was sampled in, its period and mode
  bit     m_on [N_CH];
  longint m_w  [N_CH];
  longint m_p  [N_CH];
  bit     m_os [N_CH];
  longint ack_cyc = -1;
  longint err_cyc = -1;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      m_on[i] = 1'b0;
      m_w[i]  = 0;
      m_p[i]  = 0;
      m_os[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) m_on[i] <= 1'b0;
      ack_cyc <= -1;
      err_cyc <= -1;
    end else if (cfg.cfg_we) begin
      if (int'(cfg.cfg_ch) < N_CH) begin
        m_on[cfg.cfg_ch] <= cfg.cfg_en;
        m_w[cfg.cfg_ch]  <= cyc;
        m_p[cfg.cfg_ch]  <= longint'(cfg.cfg_period);
        m_os[cfg.cfg_ch] <= cfg.cfg_mode;
        ack_cyc          <= cyc + 1;
      end else begin
        err_cyc <= cyc + 1;
      end
    end
    cyc <= cyc + 1;
  end

  // Ticks counted from the write: first at W+2+P, then every P+1 cycles
  function automatic longint n_ticks(int ch, longint c);
    longint d;
    d = c - m_w[ch] - 2 - m_p[ch];
    if (!m_on[ch] || d < 0) return 0;
    if (m_os[ch]) return 1;
    return d / (m_p[ch] + 1) + 1;
  endfunction

  function automatic bit e_tick(int ch, longint c);
    longint d;
    d = c - m_w[ch] - 2 - m_p[ch];
    if (!m_on[ch] || d < 0) return 1'b0;
    if (m_os[ch]) return d == 0;
    return (d % (m_p[ch] + 1)) == 0;
  endfunction

  function automatic bit e_active(int ch, longint c);
    if (!m_on[ch] || c < m_w[ch] + 1) return 1'b0;
    return !m_os[ch] || (c <= m_w[ch] + 1 + m_p[ch]);
  endfunction

  task automatic check(string name, int ch, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d cycle %0d: got %0h, expected %0h", name, ch, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        check("tick",    ch, 32'(tick[ch]),    32'(e_tick(ch, cyc)));
        check("active",  ch, 32'(active[ch]),  32'(e_active(ch, cyc)));
        check("div_clk", ch, 32'(div_clk[ch]), 32'(n_ticks(ch, cyc) % 2));
      end
      check("cfg_ack", 0, 32'(cfg.cfg_ack), 32'(ack_cyc == cyc));
      check("cfg_err", 0, 32'(cfg.cfg_err), 32'(err_cyc == cyc));
    end
  end

  task automatic to_cycle(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(int c);
    to_cycle(c);
    @(negedge clk);
  endtask

  task automatic wr(int t, logic [1:0] ch, logic [CNT_W-1:0] p, logic mode, logic en);
    to_cycle(t);
    cfg.cfg_we     = 1'b1;
    cfg.cfg_ch     = ch;
    cfg.cfg_period = p;
    cfg.cfg_mode   = mode;
    cfg.cfg_en     = en;
    @(posedge clk);
    #1;
    cfg.cfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    cfg.cfg_we     = 1'b0;
    cfg.cfg_ch     = 2'd0;
    cfg.cfg_period = '0;
    cfg.cfg_mode   = 1'b0;
    cfg.cfg_en     = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    to_cycle(3);
    rst = 1'b0;
    at(3);
    check("rst_tick",   0, 32'(tick),        32'd0);
    check("rst_div",    0, 32'(div_clk),     32'd0);
    check("rst_active", 0, 32'(active),      32'd0);
    check("rst_ack",    0, 32'(cfg.cfg_ack), 32'd0);

    // ch0 periodic P=3 written in cycle 10
    wr(10, 2'd0, 26'd3, 1'b0, 1'b1);
    at(11); check("p3_ack11",    0, 32'(cfg.cfg_ack), 32'd1);
            check("p3_active11", 0, 32'(active[0]),   32'd1);
    at(14); check("p3_tick14",   0, 32'(tick[0]),     32'd0);
    at(15); check("p3_tick15",   0, 32'(tick[0]),     32'd1);
            check("p3_div15",    0, 32'(div_clk[0]),  32'd1);
    at(16); check("p3_tick16",   0, 32'(tick[0]),     32'd0);
    at(18); check("p3_div18",    0, 32'(div_clk[0]),  32'd1);
    at(19); check("p3_tick19",   0, 32'(tick[0]),     32'd1);
            check("p3_div19",    0, 32'(div_clk[0]),  32'd0);
    at(22); check("p3_div22",    0, 32'(div_clk[0]),  32'd0);
    at(23); check("p3_tick23",   0, 32'(tick[0]),     32'd1);

    // ch1 one-shot P=0 written in cycle 25
    wr(25, 2'd1, 26'd0, 1'b1, 1'b1);
    at(26); check("os_active26", 1, 32'(active[1]),  32'd1);
            check("os_tick26",   1, 32'(tick[1]),    32'd0);
    at(27); check("os_tick27",   1, 32'(tick[1]),    32'd1);
            check("os_active27", 1, 32'(active[1]),  32'd0);
    at(28); check("os_tick28",   1, 32'(tick[1]),    32'd0);
    at(30); check("os_div30",    1, 32'(div_clk[1]), 32'd1);

    // Out-of-range channel
    wr(32, 2'd3, 26'd7, 1'b0, 1'b1);
    at(33); check("bad_err33", 0, 32'(cfg.cfg_err), 32'd1);
            check("bad_ack33", 0, 32'(cfg.cfg_ack), 32'd0);
    at(34); check("bad_err34", 0, 32'(cfg.cfg_err), 32'd0);

    // ch0 P=5, then identical rewrite on the edge where cnt==5
    wr(40, 2'd0, 26'd5, 1'b0, 1'b1);
    wr(46, 2'd0, 26'd5, 1'b0, 1'b1);
    at(47); check("rw_tick47", 0, 32'(tick[0]),     32'd0);
            check("rw_ack47",  0, 32'(cfg.cfg_ack), 32'd1);
    at(52); check("rw_tick52", 0, 32'(tick[0]),     32'd0);
    at(53); check("rw_tick53", 0, 32'(tick[0]),     32'd1);

    // Back-to-back writes, then reset mid-run
    wr(60, 2'd0, 26'd0, 1'b0, 1'b1);
    wr(61, 2'd1, 26'd1, 1'b0, 1'b1);
    wr(62, 2'd2, 26'd2, 1'b0, 1'b1);
    at(63); check("b2b_ack63", 0, 32'(cfg.cfg_ack), 32'd1);
    at(66); check("b2b_tick66", 0, 32'(tick), 32'b111);
    to_cycle(70);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    at(71); check("mr_tick71",   0, 32'(tick),    32'd0);
            check("mr_div71",    0, 32'(div_clk), 32'd0);
            check("mr_active71", 0, 32'(active),  32'd0);
    at(76); check("mr_tick76",   0, 32'(tick),    32'd0);

    // Reset and write on the same edge
    to_cycle(80);
    rst            = 1'b1;
    cfg.cfg_we     = 1'b1;
    cfg.cfg_ch     = 2'd0;
    cfg.cfg_period = 26'd1;
    cfg.cfg_mode   = 1'b0;
    cfg.cfg_en     = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cfg.cfg_we = 1'b0;
    at(81); check("rw_rst_ack81",    0, 32'(cfg.cfg_ack), 32'd0);
            check("rw_rst_active81", 0, 32'(active[0]),   32'd0);

    // Long period, then disable
    wr(90, 2'd2, 26'd19_999_999, 1'b0, 1'b1);
    at(150); check("long_active150", 2, 32'(active[2]), 32'd1);
    wr(190, 2'd2, 26'd19_999_999, 1'b0, 1'b0);
    at(200); check("long_active200", 2, 32'(active[2]),  32'd0);
             check("long_div200",    2, 32'(div_clk[2]), 32'd0);
             check("long_tick200",   2, 32'(tick[2]),    32'd0);

    // Maximum period is accepted and runs
    wr(210, 2'd1, 26'h3FF_FFFF, 1'b0, 1'b1);
    at(215); check("max_active215", 1, 32'(active[1]), 32'd1);
             check("max_tick215",   1, 32'(tick[1]),   32'd0);

    at(230);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
